// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio-path definitions: sample width, sample type and
//               a saturation helper used by the filter stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    // Clamp a signed value into the range of a width-bit two's-complement word.
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_ring_buffer.sv
// ============================================================================
// Module      : sample_ring_buffer
// Description : Delay line of 2^DEPTH_LOG2 words; exposes the oldest entry and
//               overwrites it with the new word on push. Async clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_ring_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] oldest_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (push_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + 1'b1;
        end
    end

    // Combinational read of the slot about to be overwritten: read-before-write.
    assign oldest_o = mem_q[ptr_q];

endmodule

`default_nettype wire

// File: rtl/high_pass_filter.sv
// ============================================================================
// Module      : high_pass_filter
// Description : Subtracts the N-sample moving average from each input sample,
//               saturating the result to the sample width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module high_pass_filter
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = SAMPLE_WIDTH,
    parameter int LOG2_WINDOW = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         out_valid,
    output logic                         primed
);

    localparam int N      = 1 << LOG2_WINDOW;
    localparam int SUM_W  = DATA_WIDTH + LOG2_WINDOW;
    localparam int FILL_W = LOG2_WINDOW + 1;

    logic signed [DATA_WIDTH-1:0] oldest;
    logic signed [SUM_W-1:0]      sum_q;
    logic signed [SUM_W-1:0]      sum_d;
    logic signed [SUM_W-1:0]      avg;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH-1:0] sample_out_d;
    logic signed [DATA_WIDTH-1:0] sample_out_q;
    logic [FILL_W-1:0]            fill_q;
    logic [FILL_W-1:0]            fill_d;
    logic                         out_valid_q;
    logic                         primed_q;

    sample_ring_buffer #(
        .DEPTH_LOG2 (LOG2_WINDOW),
        .WIDTH      (DATA_WIDTH)
    ) u_ring (
        .clk      (clk),
        .rst_i    (reset),
        .push_i   (enable),
        .data_i   (sample_in),
        .oldest_o (oldest)
    );

    always_comb begin
        sum_d        = sum_q - SUM_W'(oldest) + SUM_W'(sample_in);
        avg          = sum_d >>> LOG2_WINDOW;
        diff         = (DATA_WIDTH+1)'(sample_in) - (DATA_WIDTH+1)'(avg);
        sample_out_d = DATA_WIDTH'(saturate(32'(diff), DATA_WIDTH));
        fill_d       = (fill_q == FILL_W'(N)) ? fill_q : fill_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q        <= '0;
            sample_out_q <= '0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            out_valid_q <= enable;
            if (enable) begin
                sum_q        <= sum_d;
                sample_out_q <= sample_out_d;
                fill_q       <= fill_d;
                // Rises together with the output of the N-th sample.
                primed_q     <= primed_q | (fill_d == FILL_W'(N));
            end
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign primed     = primed_q;

endmodule

`default_nettype wire

// File: tb/tb_high_pass_filter.sv
// ============================================================================
// Module      : tb_high_pass_filter
// Description : Self-checking bench for high_pass_filter against a window-mean
//               reference model, with directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_high_pass_filter;

    localparam int N    = 8;
    localparam int SMAX = 32767;
    localparam int SMIN = -32768;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               primed;

    int checks   = 0;
    int failures = 0;

    int hist[$];
    int seen;
    int exp_out;

    high_pass_filter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sample_in  (sample_in),
        .sample_out (sample_out),
        .out_valid  (out_valid),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(0);
        seen    = 0;
        exp_out = 0;
    endfunction

    // Mean over the last N inputs (zeros before warm-up), then clamp.
    function automatic void model_push(input int x);
        int s;
        int d;
        hist.push_back(x);
        void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        d = x - floor_div(s, N);
        exp_out = (d > SMAX) ? SMAX : (d < SMIN) ? SMIN : d;
        seen++;
    endfunction

    task automatic step(input bit en, input int x);
        @(negedge clk);
        enable    = en;
        sample_in = 16'(x);
        @(posedge clk);
        #1;
        if (en) model_push(x);
        check("out_valid", int'(out_valid), int'(en));
        check("sample_out", int'(sample_out), exp_out);
        check("primed", int'(primed), int'(seen >= N));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        model_reset();
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_primed", int'(primed), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int v;
        int pulses;
        do_reset();

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1000);
            if (i == 1) check("dc_first", int'(sample_out), 875);
            if (i == 4) check("dc_fourth", int'(sample_out), 500);
            if (i == 7) check("dc_primed_low", int'(primed), 0);
            if (i == 8) begin
                check("dc_eighth", int'(sample_out), 0);
                check("dc_primed_high", int'(primed), 1);
            end
        end
        step(1'b1, 1000);
        check("dc_ninth", int'(sample_out), 0);

        step(1'b1, -1000);
        check("step_neg", int'(sample_out), -1750);
        step(1'b0, 0);
        check("step_pulse_once", int'(out_valid), 0);

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, SMIN);
        step(1'b1, SMAX);
        check("sat_pos", int'(sample_out), SMAX);

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, SMAX);
        step(1'b1, SMIN);
        check("sat_neg", int'(sample_out), SMIN);

        for (int i = 0; i < 5; i++) step(1'b0, int'($urandom_range(0, 65535)) - 32768);
        check("idle_hold", int'(sample_out), SMIN);

        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, int'($urandom_range(0, 65535)) - 32768);
            pulses += int'(out_valid);
        end
        check("full_rate_pulses", pulses, 16);

        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1000);
        do_reset();
        step(1'b1, 800);
        check("midreset_out", int'(sample_out), 700);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 800);
            if (i == 6) check("midreset_not_primed", int'(primed), 0);
            if (i == 7) check("midreset_primed", int'(primed), 1);
        end

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       v = SMAX;
                1:       v = SMIN;
                default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            if ($urandom_range(0, 99) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/high_pass_filter.md
Name: high_pass_filter

Overview:
- Complementary block to the moving-average low-pass stage.
- Removes the DC and low-frequency content from the audio sample stream: out = x[n] − mean(x[n..n−N+1]).
- Sits on the same enable-strobed sample path between the audio source and the downstream music-processing stages.
- Window length is a power of two, so the divide is an arithmetic shift; the result saturates to the sample width.

Parameters:
- data_width, 16, signed sample width in bits.
- log2_window, 3, log2 of the window length N (N = 8 by default); legal range 1..6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  single-cycle strobe: sample_in is valid this cycle.
- sample_in  input  data_width  signed two's-complement input sample.
- sample_out  output  data_width  signed high-passed sample, registered.
- out_valid  output  1  one-cycle pulse marking a new sample_out.
- primed  output  1  high once N samples have entered since reset.

Behaviour:
- Reset (async, high):
  - sample_out = 0, out_valid = 0, primed = 0.
  - Running sum = 0, write pointer = 0, fill counter = 0.
  - Every delay-line entry = 0.
  - Reset asserted mid-stream discards all history. The first enable after release behaves as sample #1.
- Delay line: N-entry ring buffer of data_width signed words, indexed by a log2_window-bit write pointer that wraps N−1 → 0.
- On an enable cycle, all of the following use the values registered before that edge:
  - oldest = buffer[wr_ptr].
  - sum_next = sum − oldest + sample_in, computed in data_width+log2_window bits signed. It cannot overflow.
  - avg = sum_next >>> log2_window (arithmetic shift, floor toward −inf).
  - diff = sample_in − avg, computed in data_width+1 bits signed.
  - sample_out = diff saturated to [−2^(dw−1), 2^(dw−1)−1].
  - buffer[wr_ptr] ← sample_in; wr_ptr ← wr_ptr+1 (mod N); sum ← sum_next.
  - out_valid = 1 for exactly the following cycle.
- Latency: sample_out and out_valid update at the clock edge that samples enable, so they are visible one cycle after the strobe.
- Enable low: no state changes; sample_out holds its last value; out_valid = 0.
- Back-to-back enables every cycle are supported at full rate, one output per cycle.
- Warm-up: before N samples, the zero-filled entries count as history, so the average is taken over N including the zeros. This is not a partial-window average.
- Fill counter saturates at N. primed rises with the output of the N-th sample and stays high until reset.
- Single-port ring buffer: the read and the write of the same entry in one enable cycle are required read-before-write.

Decomposition:
- Shared package (audio_pkg) holds:
  - the sample-width constant (16);
  - a saturate-to-sample-width function;
  - the signed sample typedef.
  - The low-pass filter reuses all three.
- One natural sub-module: sample_ring_buffer (parameterized depth/width, read-oldest/write-new, async clear). It is shared with the low-pass filter's delay line.
- Running sum, shift, subtract and saturation stay in the top module.

Test Plan:
- Reset check: assert reset with no clock edge -> sample_out = 0, out_valid = 0, primed = 0 immediately (asynchronous).
- DC warm-up, N = 8: eight enables with sample_in = 1000.
  - 1st output = 875 (avg 125).
  - 4th output = 500 (avg 500).
  - 8th output = 0, and primed rises with that output.
  - A 9th sample of 1000 -> output 0.
- Step after priming: after eight 1000s, one input of −1000 -> sum = 6000, avg = 750, sample_out = −1750, out_valid pulses once.
- Saturation: eight inputs of −32768, then 32767 -> sum = −196609, avg = −24577, diff = 57344, sample_out = 32767. The mirrored case is eight 32767s then −32768 -> sample_out = −32768.
- Enable gaps and full rate:
  - Enable low for 5 cycles -> sample_out unchanged, out_valid = 0, primed unchanged.
  - Enable high on 16 consecutive cycles -> 16 out_valid pulses, with outputs matching a reference model.
  - The pointer wraps twice with no dropped sample.
- Reset mid-operation: four samples of 1000, then reset pulse, then one sample of 800 -> avg = 100, sample_out = 700, primed = 0 until seven more samples arrive.
